inst_feeder: RTL

INST_FEEDER -- requirements
Module: inst_feeder

---
 rtl/inst_feeder.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_feeder.sv
// Instruction feeder: assembles UART bytes into little-endian 32-bit words,
// buffers them in a 4-entry FIFO and presents one word per new fetch PC.
// A fetch PC that repeats the last consuming PC receives NOP_WORD, so a
// stalled fetch never consumes a second buffered instruction.
module inst_feeder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        flush,
  input  logic [31:0] inst_mem_in,
  output logic [31:0] inst_mem_out,
  output logic        issued,
  output logic [2:0]  fifo_count,
  output logic [1:0]  byte_idx
);

  localparam logic [2:0] FULL = 3'(FIFO_DEPTH);

  // Storage: no reset, only ever read once written
  logic [31:0] r_fifo [0:FIFO_DEPTH-1];
  logic [23:0] r_asm;

  // Control state
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_last_pc;
  logic        r_pc_seen;

  logic        w_ready;
  logic        w_accept;
  logic        w_push;
  logic        w_issue;
  logic [31:0] w_word;

  // Backpressure only matters when the 4th byte would have nowhere to go
  assign w_ready  = !((r_byte_idx == 2'd3) && (r_count == FULL));
  assign w_accept = rx_valid & w_ready;
  assign w_push   = w_accept & (r_byte_idx == 2'd3);
  assign w_issue  = (r_count != 3'd0) &&
                    (!r_pc_seen || (inst_mem_in != r_last_pc));
  assign w_word   = {rx_data, r_asm};

  assign rx_ready     = w_ready;
  assign issued       = w_issue;
  assign inst_mem_out = w_issue ? r_fifo[r_rd_ptr] : NOP_WORD;
  assign fifo_count   = r_count;
  assign byte_idx     = r_byte_idx;

  // Control: reset beats flush; flush discards buffers but keeps PC history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_byte_idx <= 2'd0;
      r_last_pc  <= 32'd0;
      r_pc_seen  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_byte_idx <= 2'd0;
    end else begin
      if (w_accept)
        r_byte_idx <= r_byte_idx + 2'd1;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_issue) begin
        r_rd_ptr  <= r_rd_ptr + 2'd1;
        r_last_pc <= inst_mem_in;
        r_pc_seen <= 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data: collect bytes 0..2, write the completed word on byte 3
  always_ff @(posedge clk) begin
    if (w_accept) begin
      case (r_byte_idx)
        2'd0:    r_asm[7:0]   <= rx_data;
        2'd1:    r_asm[15:8]  <= rx_data;
        2'd2:    r_asm[23:16] <= rx_data;
        default: r_fifo[r_wr_ptr] <= w_word;
      endcase
    end
  end

endmodule
